// File: rtl/instruction_fetch_queue.sv
// ---------------------------------------------------------------------------
// instruction_fetch_queue
//
// Assembles a wide instruction from successive narrow memory beats, low beat
// first, and buffers completed instructions in a small circular FIFO feeding
// the decode/control logic through a valid/ready handshake.
//
// Parameters
//   BUS_W    width of one memory beat
//   INSTR_W  instruction width, integer multiple of BUS_W (ratio >= 2)
//   DEPTH    completed instructions buffered, power of two, >= 2
//
// Ports
//   Clock      rising-edge clock
//   Reset      asynchronous active-high reset, clears all state
//   I          memory data beat
//   Write      beat valid; accepted when Write && !Full
//   Clear      synchronous flush of partial assembly and queue
//   IRReady    consumer accepts the head instruction
//   IROut      head instruction, 0 when IRValid is low
//   IRValid    queue non-empty
//   Full       queue holds DEPTH instructions; beats are rejected
//   BeatCount  beats already held in the partial assembly
//   Level      instructions currently queued
//   Overflow   sticky dropped-beat flag (only with IR_OVERFLOW_FLAG_EN)
//
// Optional feature macro: IR_OVERFLOW_FLAG_EN adds the Overflow output.
// All outputs are decodes of registered state; no input reaches an output
// combinationally.
// ---------------------------------------------------------------------------
module instruction_fetch_queue #(
    parameter int BUS_W   = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 2
) (
    input  logic                                 Clock,
    input  logic                                 Reset,
    input  logic [BUS_W-1:0]                     I,
    input  logic                                 Write,
    input  logic                                 Clear,
    input  logic                                 IRReady,
    output logic [INSTR_W-1:0]                   IROut,
    output logic                                 IRValid,
    output logic                                 Full,
    output logic [$clog2(INSTR_W/BUS_W)-1:0]     BeatCount,
    output logic [$clog2(DEPTH+1)-1:0]           Level
`ifdef IR_OVERFLOW_FLAG_EN
    ,
    output logic                                 Overflow
`endif
);

    localparam int BEATS = INSTR_W / BUS_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    // Only the lower BEATS-1 beats are ever held; the final beat goes
    // straight into the queue entry together with them.
    localparam int ASM_W = INSTR_W - BUS_W;

    logic [ASM_W-1:0]   asm_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   level_r;
    logic [INSTR_W-1:0] mem_r [DEPTH];

    logic               full_s;
    logic               valid_s;
    logic               accept_s;
    logic               last_beat_s;
    logic               push_s;
    logic               pop_s;
    logic [INSTR_W-1:0] push_data_s;
    logic [31:0]        shamt_s;
    logic [ASM_W-1:0]   slot_mask_s;
    logic [ASM_W-1:0]   asm_next_s;
    logic [CNT_W-1:0]   cnt_next_s;
    logic [LVL_W-1:0]   level_next_s;

    assign full_s      = (level_r == LVL_W'(DEPTH));
    assign valid_s     = (level_r != {LVL_W{1'b0}});
    assign accept_s    = Write && !full_s;
    assign last_beat_s = (cnt_r == CNT_W'(BEATS - 1));
    // Clear wins over both sides of the queue in the same cycle.
    assign push_s      = accept_s && last_beat_s && !Clear;
    assign pop_s       = valid_s && IRReady && !Clear;
    assign push_data_s = {I, asm_r};
    assign shamt_s     = 32'(cnt_r) * 32'(BUS_W);
    assign slot_mask_s = ASM_W'({BUS_W{1'b1}}) << shamt_s;

    // Next assembly contents and beat counter.
    always_comb begin
        asm_next_s = asm_r;
        cnt_next_s = cnt_r;
        if (Clear) begin
            asm_next_s = {ASM_W{1'b0}};
            cnt_next_s = {CNT_W{1'b0}};
        end else if (accept_s) begin
            if (last_beat_s) begin
                asm_next_s = {ASM_W{1'b0}};
                cnt_next_s = {CNT_W{1'b0}};
            end else begin
                asm_next_s = (asm_r & ~slot_mask_s) | (ASM_W'(I) << shamt_s);
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else begin
            asm_next_s = asm_r;
            cnt_next_s = cnt_r;
        end
    end

    // Next queue occupancy from the push/pop pair.
    always_comb begin
        level_next_s = level_r;
        if (Clear) begin
            level_next_s = {LVL_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   level_next_s = level_r + LVL_W'(1);
                2'b01:   level_next_s = level_r - LVL_W'(1);
                default: level_next_s = level_r;
            endcase
        end
    end

    // Assembly, counter, pointer, level and storage registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            asm_r    <= {ASM_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {INSTR_W{1'b0}};
            end
        end else begin
            asm_r   <= asm_next_s;
            cnt_r   <= cnt_next_s;
            level_r <= level_next_s;
            if (Clear) begin
                wr_ptr_r <= {PTR_W{1'b0}};
                rd_ptr_r <= {PTR_W{1'b0}};
            end else begin
                // Pointers wrap naturally because DEPTH is a power of two.
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
            end
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
            end
        end
    end

    // Head presentation: stale storage is masked while the queue is empty.
    always_comb begin
        if (valid_s) begin
            IROut = mem_r[rd_ptr_r];
        end else begin
            IROut = {INSTR_W{1'b0}};
        end
    end

    assign IRValid   = valid_s;
    assign Full      = full_s;
    assign BeatCount = cnt_r;
    assign Level     = level_r;

`ifdef IR_OVERFLOW_FLAG_EN
    logic ovf_r;

    // Sticky record of any beat dropped because the queue was full.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ovf_r <= 1'b0;
        end else if (Clear) begin
            ovf_r <= 1'b0;
        end else if (Write && full_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign Overflow = ovf_r;
`endif

endmodule
